// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and data ports onto a byte-wide synchronous-read RAM
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              mem_done_o,
  output logic              stall_req_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_we_o,
  input  logic [7:0]        ram_din_i
);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, f_q, n_q, f_d, n_d, lane, cap_lane_q;
  logic [ADDR_W-1:0] base_q, addr_q, addr_cur;
  logic [31:0] data_q, buf_q, merged, req_addr;
  logic [3:0] acc_sel;
  logic we_q, is_mem_q, cap_q, mem_elig, if_elig, acc, zero, xfer, last;
  logic unused_ok;
  assign mem_elig = mem_ce_i & ~mem_done_o;
  assign if_elig = if_ce_i & ~if_done_o;
  assign acc = (state_q == IDLE) & (mem_elig | if_elig);
  assign zero = mem_elig & (mem_sel_i == 4'b0000);
  assign acc_sel = mem_elig ? mem_sel_i : 4'b1111;
  assign req_addr = mem_elig ? mem_addr_i : if_addr_i;
  assign unused_ok = ^{req_addr[31:ADDR_W], req_addr[1:0]};
  assign xfer = state_q == XFER;
  assign last = cnt_q == n_q;
  assign lane = f_q + cnt_q;
  assign addr_cur = base_q + ADDR_W'(f_q) + ADDR_W'(cnt_q);
  assign ram_addr_o = xfer ? addr_cur : addr_q;
  assign ram_we_o = xfer & we_q;
  assign ram_dout_o = ram_we_o ? data_q[{lane, 3'b000} +: 8] : 8'd0;
  assign stall_req_o = rst & ((if_ce_i & ~if_done_o) | (mem_ce_i & ~mem_done_o));
  always_comb begin
    f_d = 2'd0;
    n_d = 2'd3;
    case (acc_sel)
      4'b0001: n_d = 2'd0;
      4'b0010: begin f_d = 2'd1; n_d = 2'd0; end
      4'b0100: begin f_d = 2'd2; n_d = 2'd0; end
      4'b1000: begin f_d = 2'd3; n_d = 2'd0; end
      4'b0011: n_d = 2'd1;
      4'b1100: begin f_d = 2'd2; n_d = 2'd1; end
      default: ;
    endcase
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (acc & ~zero) ? XFER : IDLE;
      XFER:    state_d = last ? (we_q ? IDLE : DRAIN) : XFER;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    merged = buf_q;
    if (cap_q) merged[{cap_lane_q, 3'b000} +: 8] = ram_din_i;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      f_q        <= '0;
      n_q        <= '0;
      cap_lane_q <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      buf_q      <= '0;
      we_q       <= 1'b0;
      is_mem_q   <= 1'b0;
      cap_q      <= 1'b0;
      if_data_o  <= '0;
      mem_data_o <= '0;
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      cap_q      <= xfer & ~we_q;
      cap_lane_q <= lane;
      if (cap_q) buf_q <= merged;
      if (xfer) begin
        addr_q <= addr_cur;
        cnt_q  <= cnt_q + 2'd1;
      end
      if (xfer & last & we_q) mem_done_o <= 1'b1;
      if (state_q == DRAIN) begin
        if (is_mem_q) begin
          mem_done_o <= 1'b1;
          mem_data_o <= merged;
        end else begin
          if_done_o <= 1'b1;
          if_data_o <= merged;
        end
      end
      if (acc) begin
        is_mem_q <= mem_elig;
        we_q     <= mem_elig & mem_we_i;
        base_q   <= {req_addr[ADDR_W-1:2], 2'b00};
        data_q   <= mem_data_i;
        f_q      <= f_d;
        n_q      <= n_d;
        cnt_q    <= '0;
        buf_q    <= '0;
        if (zero) begin
          mem_done_o <= 1'b1;
          if (!mem_we_i) mem_data_o <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a byte RAM model
module tb_mem_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic if_ce_i = 1'b0, if_done_o, mem_ce_i = 1'b0, mem_we_i = 1'b0, mem_done_o;
  logic stall_req_o, ram_we_o;
  logic [31:0] if_addr_i = '0, if_data_o, mem_addr_i = '0, mem_data_i = '0, mem_data_o;
  logic [3:0] mem_sel_i = '0;
  logic [16:0] ram_addr_o;
  logic [7:0] ram_dout_o, ram_din_i;
  logic [7:0] ram [0:(1<<17)-1];
  logic ld_we = 1'b0;
  logic [16:0] ld_a = '0;
  logic [7:0] ld_d = '0;
  int pass_cnt = 0, total = 0;
  mem_ctrl #(.ADDR_W(17)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_done_o(mem_done_o),
    .stall_req_o(stall_req_o), .ram_addr_o(ram_addr_o), .ram_dout_o(ram_dout_o),
    .ram_we_o(ram_we_o), .ram_din_i(ram_din_i)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we_o) ram[ram_addr_o] <= ram_dout_o;
    if (ld_we) ram[ld_a] <= ld_d;
    ram_din_i <= ram[ram_addr_o];
  end
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask
  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    ld_we = 1'b1; ld_a = a; ld_d = d;
    nxt();
    ld_we = 1'b0;
  endtask
  task automatic mem_req(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = a; mem_sel_i = s; mem_data_i = d;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      nxt();
      if_ce_i = 1'($urandom); if_addr_i = $urandom; mem_ce_i = 1'($urandom);
      mem_we_i = 1'($urandom); mem_addr_i = $urandom; mem_sel_i = 4'($urandom);
      mem_data_i = $urandom;
      #1;
      total++;
      if ({if_data_o, mem_data_o, if_done_o, mem_done_o, stall_req_o, ram_addr_o, ram_dout_o, ram_we_o} !== '0)
        $display("FAIL reset_outputs[%0d] got if=%h mem=%h dn=%b%b st=%b ra=%h rd=%h we=%b exp all 0", i,
                 if_data_o, mem_data_o, if_done_o, mem_done_o, stall_req_o, ram_addr_o, ram_dout_o, ram_we_o);
      else pass_cnt++;
    end
    if_ce_i = 0; mem_ce_i = 0; mem_we_i = 0; mem_sel_i = 0; mem_addr_i = 0; mem_data_i = 0; if_addr_i = 0;
    nxt();
    rst = 1'b1;
  endtask
  task automatic test_fetch();
    nxt();
    if_addr_i = 32'h102; if_ce_i = 1'b1;
    #1;
    total++; if (stall_req_o !== 1'b1) $display("FAIL fetch_stall got %b exp 1", stall_req_o); else pass_cnt++;
    total++; if (ram_addr_o !== 17'h0) $display("FAIL fetch_addr_T got %h exp 0", ram_addr_o); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      nxt();
      total++;
      if (ram_addr_o !== 17'h100 + 17'(k) || ram_we_o !== 1'b0)
        $display("FAIL fetch_addr%0d got %h we=%b exp %h we=0", k, ram_addr_o, ram_we_o, 17'h100 + 17'(k));
      else pass_cnt++;
    end
    nxt();
    total++; if (if_done_o !== 1'b0) $display("FAIL fetch_early_done got %b exp 0", if_done_o); else pass_cnt++;
    nxt();
    total++;
    if (if_done_o !== 1'b1 || if_data_o !== 32'h00000513)
      $display("FAIL fetch_done got done=%b data=%h exp 1 00000513", if_done_o, if_data_o);
    else pass_cnt++;
    if_ce_i = 1'b0;
    nxt();
    total++; if (if_done_o !== 1'b0) $display("FAIL fetch_pulse got %b exp 0", if_done_o); else pass_cnt++;
  endtask
  task automatic test_byte_store();
    nxt();
    mem_req(1'b1, 32'h202, 4'b0100, 32'h00AB0000);
    nxt();
    total++;
    if ({ram_we_o, ram_addr_o, ram_dout_o} !== {1'b1, 17'h202, 8'hAB})
      $display("FAIL bstore_write got we=%b a=%h d=%h exp 1 202 ab", ram_we_o, ram_addr_o, ram_dout_o);
    else pass_cnt++;
    nxt();
    total++;
    if (mem_done_o !== 1'b1 || ram_we_o !== 1'b0)
      $display("FAIL bstore_done got done=%b we=%b exp 1 0", mem_done_o, ram_we_o);
    else pass_cnt++;
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    nxt();
    total++;
    if ({ram[17'h203], ram[17'h202], ram[17'h201], ram[17'h200]} !== 32'h44AB2211)
      $display("FAIL bstore_ram got %h exp 44ab2211", {ram[17'h203], ram[17'h202], ram[17'h201], ram[17'h200]});
    else pass_cnt++;
  endtask
  task automatic test_half_load();
    nxt();
    mem_req(1'b0, 32'h4, 4'b1100, 32'h0);
    nxt();
    total++; if (ram_addr_o !== 17'h6) $display("FAIL hload_addr0 got %h exp 6", ram_addr_o); else pass_cnt++;
    nxt();
    total++; if (ram_addr_o !== 17'h7) $display("FAIL hload_addr1 got %h exp 7", ram_addr_o); else pass_cnt++;
    nxt();
    total++; if (mem_done_o !== 1'b0) $display("FAIL hload_early got %b exp 0", mem_done_o); else pass_cnt++;
    nxt();
    total++;
    if (mem_done_o !== 1'b1 || mem_data_o !== 32'h12340000)
      $display("FAIL hload_done got done=%b data=%h exp 1 12340000", mem_done_o, mem_data_o);
    else pass_cnt++;
    mem_ce_i = 1'b0;
  endtask
  task automatic test_contention();
    nxt();
    if_ce_i = 1'b1; if_addr_i = 32'h20;
    mem_req(1'b0, 32'h10, 4'b1111, 32'h0);
    #1;
    total++; if (stall_req_o !== 1'b1) $display("FAIL cont_stall_T got %b exp 1", stall_req_o); else pass_cnt++;
    for (int k = 1; k <= 12; k++) begin
      nxt();
      if (k == 1) begin
        total++; if (ram_addr_o !== 17'h10) $display("FAIL cont_mem_first got %h exp 10", ram_addr_o); else pass_cnt++;
      end
      if (k == 5) begin
        total++;
        if (stall_req_o !== 1'b1 || mem_done_o !== 1'b0)
          $display("FAIL cont_t5 got stall=%b done=%b exp 1 0", stall_req_o, mem_done_o);
        else pass_cnt++;
      end
      if (k == 6) begin
        total++;
        if (mem_done_o !== 1'b1 || mem_data_o !== 32'h04030201 || if_done_o !== 1'b0)
          $display("FAIL cont_mem_done got done=%b data=%h ifd=%b exp 1 04030201 0", mem_done_o, mem_data_o, if_done_o);
        else pass_cnt++;
        mem_ce_i = 1'b0;
      end
      if (k == 7) begin
        total++; if (ram_addr_o !== 17'h20) $display("FAIL cont_if_first got %h exp 20", ram_addr_o); else pass_cnt++;
      end
      if (k == 11) begin
        total++; if (stall_req_o !== 1'b1) $display("FAIL cont_stall_t11 got %b exp 1", stall_req_o); else pass_cnt++;
      end
    end
    total++;
    if (if_done_o !== 1'b1 || if_data_o !== 32'hDEADBEEF || stall_req_o !== 1'b0 || mem_data_o !== 32'h04030201)
      $display("FAIL cont_if_done got done=%b data=%h stall=%b mdata=%h exp 1 deadbeef 0 04030201",
               if_done_o, if_data_o, stall_req_o, mem_data_o);
    else pass_cnt++;
    if_ce_i = 1'b0;
  endtask
  task automatic test_sel_edges();
    nxt();
    mem_req(1'b0, 32'h10, 4'b0000, 32'h0);
    nxt();
    total++;
    if (mem_done_o !== 1'b1 || ram_we_o !== 1'b0 || mem_data_o !== 32'h0)
      $display("FAIL zero_sel got done=%b we=%b data=%h exp 1 0 0", mem_done_o, ram_we_o, mem_data_o);
    else pass_cnt++;
    mem_ce_i = 1'b0;
    nxt();
    mem_req(1'b0, 32'h0002_0105, 4'b0010, 32'h0);
    nxt();
    total++; if (ram_addr_o !== 17'h105) $display("FAIL trunc_addr got %h exp 105", ram_addr_o); else pass_cnt++;
    nxt();
    nxt();
    total++;
    if (mem_done_o !== 1'b1 || mem_data_o !== 32'h00005A00)
      $display("FAIL trunc_load got done=%b data=%h exp 1 00005a00", mem_done_o, mem_data_o);
    else pass_cnt++;
    mem_ce_i = 1'b0;
    nxt();
    mem_req(1'b1, 32'h400, 4'b0101, 32'h44332211);
    repeat (5) nxt();
    total++; if (mem_done_o !== 1'b1) $display("FAIL odd_sel_done got %b exp 1", mem_done_o); else pass_cnt++;
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    nxt();
    total++;
    if ({ram[17'h403], ram[17'h402], ram[17'h401], ram[17'h400]} !== 32'h44332211)
      $display("FAIL odd_sel_ram got %h exp 44332211", {ram[17'h403], ram[17'h402], ram[17'h401], ram[17'h400]});
    else pass_cnt++;
  endtask
  task automatic test_reset_mid_store();
    logic seen_done;
    nxt();
    mem_req(1'b1, 32'h300, 4'b1111, 32'hDDCCBBAA);
    nxt();
    nxt();
    total++;
    if (ram_we_o !== 1'b1 || ram_addr_o !== 17'h301)
      $display("FAIL rst_store_t2 got we=%b a=%h exp 1 301", ram_we_o, ram_addr_o);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
    #1;
    total++;
    if (ram_we_o !== 1'b0 || ram_addr_o !== 17'h0)
      $display("FAIL rst_async got we=%b a=%h exp 0 0", ram_we_o, ram_addr_o);
    else pass_cnt++;
    seen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      seen_done = seen_done | mem_done_o;
    end
    total++; if (seen_done !== 1'b0) $display("FAIL rst_no_done got %b exp 0", seen_done); else pass_cnt++;
    rst = 1'b1;
    total++;
    if ({ram[17'h303], ram[17'h302], ram[17'h301], ram[17'h300]} !== 32'h0000BBAA)
      $display("FAIL rst_ram got %h exp 0000bbaa", {ram[17'h303], ram[17'h302], ram[17'h301], ram[17'h300]});
    else pass_cnt++;
    nxt();
    mem_req(1'b0, 32'h300, 4'b0010, 32'h0);
    nxt();
    nxt();
    nxt();
    total++;
    if (mem_done_o !== 1'b1 || mem_data_o !== 32'h0000BB00)
      $display("FAIL rst_reload got done=%b data=%h exp 1 0000bb00", mem_done_o, mem_data_o);
    else pass_cnt++;
    mem_ce_i = 1'b0;
    nxt();
  endtask
  initial begin
    poke(17'h100, 8'h13); poke(17'h101, 8'h05); poke(17'h102, 8'h00); poke(17'h103, 8'h00);
    poke(17'h200, 8'h11); poke(17'h201, 8'h22); poke(17'h202, 8'h33); poke(17'h203, 8'h44);
    poke(17'h6, 8'h34); poke(17'h7, 8'h12);
    poke(17'h10, 8'h01); poke(17'h11, 8'h02); poke(17'h12, 8'h03); poke(17'h13, 8'h04);
    poke(17'h20, 8'hEF); poke(17'h21, 8'hBE); poke(17'h22, 8'hAD); poke(17'h23, 8'hDE);
    poke(17'h105, 8'h5A);
    poke(17'h300, 8'h00); poke(17'h301, 8'h00); poke(17'h302, 8'h00); poke(17'h303, 8'h00);
    test_reset();
    test_fetch();
    test_byte_store();
    test_half_load();
    test_contention();
    test_sel_edges();
    test_reset_mid_store();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sits directly downstream of the CPU core's instruction-fetch port (rom_*) and data-memory port (ram_*).
- Arbitrates the two ports onto one single-port, byte-wide, synchronous-read external RAM.
- Serialises each 32-bit access into 1/2/4 byte transfers.
- Returns a completion pulse per port and raises a pipeline stall request while a port waits.

Parameters:
ADDR_W, 17, external RAM byte-address width; request addresses are truncated to the low ADDR_W bits.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
if_ce_i  input  1  fetch request; held high until if_done_o
if_addr_i  input  32  fetch byte address; bits[1:0] ignored (forced 00)
if_data_o  output  32  fetched word, little-endian; held until next fetch completes
if_done_o  output  1  one-cycle fetch completion pulse
mem_ce_i  input  1  data request; held high until mem_done_o
mem_we_i  input  1  1 = store, 0 = load
mem_addr_i  input  32  data address; word base = {addr[31:2],2'b00}
mem_sel_i  input  4  byte-lane enables
mem_data_i  input  32  store data, lane-aligned
mem_data_o  output  32  load data, lane-aligned, unselected lanes 0; held until next load completes
mem_done_o  output  1  one-cycle data completion pulse
stall_req_o  output  1  request to stall the pipeline
ram_addr_o  output  ADDR_W  external RAM byte address
ram_dout_o  output  8  external RAM write byte
ram_we_o  output  1  external RAM write enable
ram_din_i  input  8  external RAM read byte; valid in the cycle after its address was presented

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0. All outputs 0 (if_data_o, mem_data_o, both done pulses, stall_req_o, ram_addr_o, ram_dout_o, ram_we_o). An in-flight transfer is abandoned; bytes already written stay in RAM.
- FSM states: IDLE, XFER, DRAIN.
- IDLE acceptance, in cycle T:
  - A port is eligible if its ce is high and its done is not high in the same cycle.
  - Data port wins when both are eligible; the fetch port waits.
  - On acceptance, latch the request and go to XFER with cnt=0.
- Transfer length N and first lane f, from the latched sel:
  - 0001/0010/0100/1000 -> N=1, f = index of the set bit.
  - 0011 -> N=2, f=0; 1100 -> N=2, f=2.
  - 1111 -> N=4, f=0.
  - 0000 -> no RAM activity; done pulses in T+1.
  - Any other pattern is treated as 1111.
  - Fetch is always N=4, f=0.
- XFER, cycles T+1..T+N:
  - ram_addr_o = base + f + cnt; cnt increments each cycle.
  - Store: ram_we_o=1, ram_dout_o = mem_data_i lane (f+cnt), taken from the latched data.
  - Load/fetch: ram_we_o=0.
- Load/fetch capture: byte k is captured from ram_din_i at the edge ending cycle T+2+k into lane f+k; other lanes are cleared at accept.
- Completion:
  - Load/fetch: after the last address the FSM goes to DRAIN for one cycle (captures the final byte). Done pulses in cycle T+N+2, with data valid in the same cycle. The FSM is back in IDLE in that cycle.
  - Store: done pulses in cycle T+N+1, FSM in IDLE.
- Outside XFER: ram_we_o=0 and ram_addr_o holds its last value.
- stall_req_o (combinational) = (if_ce_i & ~if_done_o) | (mem_ce_i & ~mem_done_o).
- The done cycle is itself an IDLE cycle, so the other port's pending request is accepted in that same cycle. There is no dead cycle between transfers.
- Address wrap: base + f + cnt is computed modulo 2^ADDR_W.
- A ce drop mid-transfer is ignored: the transfer completes and done still pulses.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0. Release and assert if_ce_i -> first ram_addr_o appears one cycle after acceptance.
- Fetch: RAM[0x100..0x103] = 13 05 00 00, if_addr_i=0x102, accepted at T -> addresses 0x100..0x103 in T+1..T+4; if_data_o=0x00000513 with if_done_o=1 in T+6 only.
- Byte store: sel=0100, addr=0x202, data=0x00AB0000 at T -> exactly one write (ram_addr_o=0x200+2=0x202, ram_dout_o=0xAB) in T+1; mem_done_o in T+2; RAM[0x200,0x201,0x203] unchanged.
- Halfword load: sel=1100, addr=0x4, RAM[0x6]=0x34, RAM[0x7]=0x12 -> mem_data_o=0x12340000 with mem_done_o in T+4.
- Contention: if_ce_i and mem_ce_i (word load) rise together -> data transfer first with mem_done_o at T+6; fetch accepted at T+6 with if_done_o at T+12; stall_req_o high until T+12, low at T+12.
- Reset mid-store: rst=0 during T+2 of a 4-byte store -> ram_we_o drops immediately; only byte 0 and byte 1 are written; no done pulse; a new request after release is served normally.
